// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - datapath constants shared by the adder files
//
// Purpose: owns the default operand width used by the adder interface and top.
// Ports:   none (package).
package full_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle for the ripple-carry adder
//
// Purpose: groups operands, carry-in, qualifier and both result paths.
// Ports (signals):
//   a, b       operands, WIDTH bits
//   z          carry-in
//   in_valid   qualifies a/b/z for capture into the registered path
//   sum, carry combinational result
//   sum_q, carry_q, out_valid  registered result and its valid pulse
// Modports: master drives operands, slave (the adder) drives results.
interface full_adder_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             z;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             out_valid;

  modport master (
    output a, b, z, in_valid,
    input  sum, carry, sum_q, carry_q, out_valid
  );

  modport slave (
    input  a, b, z, in_valid,
    output sum, carry, sum_q, carry_q, out_valid
  );

endinterface

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit combinational full adder cell
//
// Purpose: single bit of the ripple-carry chain.
// Ports:
//   a, b  operand bits (in)
//   cin   carry from the next lower bit (in)
//   s     sum bit (out)
//   cout  carry to the next higher bit (out)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term reused by sum and carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - WIDTH-bit ripple-carry adder with registered result copy
//
// Purpose: combinational a + b + z plus a one-cycle-latency registered copy.
// Ports:
//   clk  rising-edge clock for the registered path
//   rst  synchronous active-high reset of the registered path
//   bus  full_adder_if.slave: a, b, z, in_valid in; sum, carry (combinational),
//        sum_q, carry_q, out_valid (registered) out
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  full_adder_if.slave      bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             valid_r;

  assign c[0] = bus.z;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder_cell u_cell (
      .a    (bus.a[gi]),
      .b    (bus.b[gi]),
      .cin  (c[gi]),
      .s    (s[gi]),
      .cout (c[gi+1])
    );
  end

  // Combinational result is independent of clk, rst and in_valid.
  assign bus.sum   = s;
  assign bus.carry = c[WIDTH];

  // Reset wins over a same-cycle capture; without in_valid the result holds
  // but out_valid drops so it pulses once per accepted input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= '0;
      carry_r <= 1'b0;
      valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      sum_r   <= s;
      carry_r <= c[WIDTH];
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bus.sum_q     = sum_r;
  assign bus.carry_q   = carry_r;
  assign bus.out_valid = valid_r;

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder
//
// Purpose: checks the combinational and registered paths at WIDTH 1, 4 and 8.
// Ports:   none (top-level bench).
module tb_full_adder;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 if (clk_en) clk = ~clk;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(4)) bus4 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  full_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed streaming vectors at WIDTH=8: {carry,sum} = a + b + z.
  logic [7:0] st_a [8] = '{8'h00, 8'hFF, 8'h80, 8'h12, 8'hA5, 8'h7F, 8'hC8, 8'h0F};
  logic [7:0] st_b [8] = '{8'h00, 8'h01, 8'h80, 8'h34, 8'h5A, 8'h00, 8'h64, 8'hF0};
  logic       st_z [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
  logic [7:0] st_s [8] = '{8'h00, 8'h00, 8'h01, 8'h46, 8'h00, 8'h80, 8'h2C, 8'hFF};
  logic       st_c [8] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};

  logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    bus1.a = '0; bus1.b = '0; bus1.z = 1'b0; bus1.in_valid = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.z = 1'b0; bus4.in_valid = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.z = 1'b0; bus8.in_valid = 1'b0;

    // Exhaustive WIDTH=1 truth table with the clock idle.
    for (int i = 0; i < 8; i++) begin
      {bus1.a, bus1.b, bus1.z} = 3'(i);
      #5;
      check($sformatf("tt_%0d", i), {62'd0, bus1.carry, bus1.sum}, {62'd0, tt_exp[i]});
      #5;
    end

    // Reset for two cycles.
    clk_en = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    check("rst_sum_q", 64'(bus1.sum_q), 64'd0);
    check("rst_carry_q", 64'(bus1.carry_q), 64'd0);
    check("rst_out_valid", 64'(bus1.out_valid), 64'd0);
    check("rst_out_valid_w8", 64'(bus8.out_valid), 64'd0);

    // Single capture then hold.
    rst = 1'b0;
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.z = 1'b1; bus1.in_valid = 1'b1;
    tick();
    check("cap_sum_q", 64'(bus1.sum_q), 64'd1);
    check("cap_carry_q", 64'(bus1.carry_q), 64'd1);
    check("cap_out_valid", 64'(bus1.out_valid), 64'd1);
    bus1.in_valid = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.z = 1'b0;
    tick();
    check("hold_sum_q", 64'(bus1.sum_q), 64'd1);
    check("hold_carry_q", 64'(bus1.carry_q), 64'd1);
    check("hold_out_valid", 64'(bus1.out_valid), 64'd0);

    // WIDTH=4 ripple through every cell.
    bus4.a = 4'd15; bus4.b = 4'd1; bus4.z = 1'b0;
    #1;
    check("w4_f_1_sum", 64'(bus4.sum), 64'd0);
    check("w4_f_1_carry", 64'(bus4.carry), 64'd1);
    bus4.a = 4'd15; bus4.b = 4'd15; bus4.z = 1'b1;
    #1;
    check("w4_f_f_1_sum", 64'(bus4.sum), 64'd15);
    check("w4_f_f_1_carry", 64'(bus4.carry), 64'd1);
    bus4.a = 4'd5; bus4.b = 4'd2; bus4.z = 1'b0;
    #1;
    check("w4_5_2_sum", 64'(bus4.sum), 64'd7);
    check("w4_5_2_carry", 64'(bus4.carry), 64'd0);

    // Reset takes priority over a same-cycle capture.
    tick();
    rst = 1'b1;
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.z = 1'b0; bus1.in_valid = 1'b1;
    #1;
    check("prio_comb_before", 64'(bus1.sum), 64'd1);
    tick();
    check("prio_sum_q", 64'(bus1.sum_q), 64'd0);
    check("prio_carry_q", 64'(bus1.carry_q), 64'd0);
    check("prio_out_valid", 64'(bus1.out_valid), 64'd0);
    check("prio_comb_after", 64'(bus1.sum), 64'd1);
    rst = 1'b0;
    bus1.in_valid = 1'b0;
    tick();
    check("prio_idle_out_valid", 64'(bus1.out_valid), 64'd0);

    // Back-to-back streaming at WIDTH=8.
    for (int i = 0; i < 8; i++) begin
      bus8.a = st_a[i]; bus8.b = st_b[i]; bus8.z = st_z[i]; bus8.in_valid = 1'b1;
      tick();
      check($sformatf("st_sum_q_%0d", i), 64'(bus8.sum_q), 64'(st_s[i]));
      check($sformatf("st_carry_q_%0d", i), 64'(bus8.carry_q), 64'(st_c[i]));
      check($sformatf("st_out_valid_%0d", i), 64'(bus8.out_valid), 64'd1);
    end
    bus8.in_valid = 1'b0;
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.z = 1'b0;
    tick();
    check("st_end_out_valid", 64'(bus8.out_valid), 64'd0);
    check("st_end_sum_q", 64'(bus8.sum_q), 64'(st_s[7]));
    check("st_end_comb_sum", 64'(bus8.sum), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
